// File: rtl/uart_hex_byte_sender.sv
// Formats one byte as two uppercase ASCII hex chars (plus optional CR LF) and
// serializes them 8N1 on uart_txd, chars back-to-back with no idle gap.
module uart_hex_byte_sender #(
   parameter int CLKS_PER_BIT = 434,
   parameter int APPEND_CRLF  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_req,
   input  logic [7:0] send_data,
   output logic       busy,
   output logic       done,
   output logic       uart_txd
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [1:0]        LAST_CHAR = (APPEND_CRLF != 0) ? 2'd3 : 2'd1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [BAUD_W-1:0]   r_baud;
   logic [2:0]          r_bit;
   logic [1:0]          r_char_idx;
   logic                r_done;
   logic [7:0]          r_data;
   logic [7:0]          r_char;
   logic                w_baud_end;
   logic                w_accept;
   logic                w_next_char;
   logic                w_finish;
   logic                w_txd;

   function automatic logic [7:0] f_hex_ascii(input logic [3:0] i_nib);
      if (i_nib <= 4'd9)
         return 8'h30 + {4'h0, i_nib};
      else
         return 8'h37 + {4'h0, i_nib};
   endfunction

   function automatic logic [7:0] f_char_at(input logic [1:0] i_idx, input logic [7:0] i_byte);
      case (i_idx)
         2'd0:    return f_hex_ascii(i_byte[7:4]);
         2'd1:    return f_hex_ascii(i_byte[3:0]);
         2'd2:    return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction

   assign w_baud_end = (r_baud == BAUD_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_next_char  = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (send_req) begin
               w_next_state = S_START;
               w_accept     = 1'b1;
            end
         end
         S_START: begin
            if (w_baud_end)
               w_next_state = S_DATA;
         end
         S_DATA: begin
            if (w_baud_end && (r_bit == 3'd7))
               w_next_state = S_STOP;
         end
         S_STOP: begin
            if (w_baud_end) begin
               if (r_char_idx == LAST_CHAR) begin
                  w_next_state = S_IDLE;
                  w_finish     = 1'b1;
               end else begin
                  w_next_state = S_START;
                  w_next_char  = 1'b1;
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Baud, bit and char counters; all return to zero whenever the FSM is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_baud     <= '0;
         r_bit      <= '0;
         r_char_idx <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= w_finish;

         if ((r_state == S_IDLE) || w_baud_end)
            r_baud <= '0;
         else
            r_baud <= r_baud + 1'b1;

         if (r_state != S_DATA)
            r_bit <= '0;
         else if (w_baud_end)
            r_bit <= r_bit + 3'd1;

         if (r_state == S_IDLE)
            r_char_idx <= '0;
         else if (w_next_char)
            r_char_idx <= r_char_idx + 2'd1;
      end
   end

   // The outgoing char is prepared on entry to START so DATA only indexes bits.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_data <= send_data;
         r_char <= f_hex_ascii(send_data[7:4]);
      end else if (w_next_char) begin
         r_char <= f_char_at(r_char_idx + 2'd1, r_data);
      end
   end

   always_comb begin
      w_txd = 1'b1;
      case (r_state)
         S_START: w_txd = 1'b0;
         S_DATA:  w_txd = r_char[r_bit];
         default: w_txd = 1'b1;
      endcase
   end

   assign uart_txd = w_txd;
   assign busy     = (r_state != S_IDLE);
   assign done     = r_done;

endmodule

// File: tb/tb_uart_hex_byte_sender.sv
// Directed bench for uart_hex_byte_sender: a behavioural UART receiver decodes
// uart_txd and each scenario compares chars, timing and status against hand values.
module tb_uart_hex_byte_sender;

   localparam int CPB_DEF = 434;
   localparam int CPB     = 16;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       send_req  = 1'b0;
   logic [7:0] send_data = 8'h00;
   logic       w_txd  [3];
   logic       w_busy [3];
   logic       w_done [3];

   int sel      = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (w_done[sel] === 1'b1) done_cnt <= done_cnt + 1;
   end

   uart_hex_byte_sender #(.CLKS_PER_BIT(CPB_DEF), .APPEND_CRLF(1)) u_dut_def (
      .clk(clk), .rst(rst), .send_req(send_req), .send_data(send_data),
      .busy(w_busy[0]), .done(w_done[0]), .uart_txd(w_txd[0]));

   uart_hex_byte_sender #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(1)) u_dut_fast (
      .clk(clk), .rst(rst), .send_req(send_req), .send_data(send_data),
      .busy(w_busy[1]), .done(w_done[1]), .uart_txd(w_txd[1]));

   uart_hex_byte_sender #(.CLKS_PER_BIT(CPB), .APPEND_CRLF(0)) u_dut_nocrlf (
      .clk(clk), .rst(rst), .send_req(send_req), .send_data(send_data),
      .busy(w_busy[2]), .done(w_done[2]), .uart_txd(w_txd[2]));

   // Receiver model: called on a negedge; samples each bit at its centre.
   task automatic rx_char(input int cpb, output logic [7:0] b, output bit ok, output int t0);
      int n;
      ok = 1'b1;
      b  = 8'h00;
      n  = 0;
      while ((w_txd[sel] !== 1'b0) && (n < 12 * cpb)) begin
         @(negedge clk);
         n++;
      end
      t0 = cyc;
      if (w_txd[sel] !== 1'b0) begin
         ok = 1'b0;
         return;
      end
      repeat (cpb / 2) @(negedge clk);
      if (w_txd[sel] !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         repeat (cpb) @(negedge clk);
         b[i] = w_txd[sel];
      end
      repeat (cpb) @(negedge clk);
      if (w_txd[sel] !== 1'b1) ok = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int t, output bit seen);
      seen = 1'b0;
      t    = 0;
      for (int i = 0; i < limit; i++) begin
         if (w_done[sel] === 1'b1) begin
            seen = 1'b1;
            t    = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      send_req = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_req(input logic [7:0] d);
      send_data = d;
      send_req  = 1'b1;
      @(negedge clk);
      send_req  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         n_checks++;
         if (w_txd[s] !== 1'b1) $display("FAIL reset_txd dut%0d: got %b want 1", s, w_txd[s]);
         else n_pass++;
         n_checks++;
         if (w_busy[s] !== 1'b0) $display("FAIL reset_busy dut%0d: got %b want 0", s, w_busy[s]);
         else n_pass++;
         n_checks++;
         if (w_done[s] !== 1'b0) $display("FAIL reset_done dut%0d: got %b want 0", s, w_done[s]);
         else n_pass++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_frame_default();
      logic [7:0] exp [4] = '{8'h41, 8'h35, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit         ok, seen;
      int         t0, t_first, t_done, cnt0;
      sel = 0;
      do_reset();
      cnt0 = done_cnt;
      pulse_req(8'hA5);
      for (int k = 0; k < 4; k++) begin
         rx_char(CPB_DEF, b, ok, t0);
         if (k == 0) t_first = t0;
         n_checks++;
         if (!ok || b !== exp[k]) $display("FAIL a5_char%0d: got %h ok=%0d want %h", k, b, ok, exp[k]);
         else n_pass++;
      end
      wait_done(2 * CPB_DEF, t_done, seen);
      n_checks++;
      if (!seen) $display("FAIL a5_done_seen: got 0 want 1");
      else n_pass++;
      n_checks++;
      if ((t_done - t_first) !== 17360) $display("FAIL a5_frame_len: got %0d want 17360", t_done - t_first);
      else n_pass++;
      n_checks++;
      if (w_busy[0] !== 1'b0) $display("FAIL a5_busy_at_done: got %b want 0", w_busy[0]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (w_done[0] !== 1'b0) $display("FAIL a5_done_width: got %b want 0", w_done[0]);
      else n_pass++;
      n_checks++;
      if ((done_cnt - cnt0) !== 1) $display("FAIL a5_done_count: got %0d want 1", done_cnt - cnt0);
      else n_pass++;
   endtask

   task automatic test_hex_chars();
      logic [7:0] din [3]    = '{8'h00, 8'hFF, 8'h9A};
      logic [7:0] exp [3][4] = '{'{8'h30, 8'h30, 8'h0D, 8'h0A},
                                 '{8'h46, 8'h46, 8'h0D, 8'h0A},
                                 '{8'h39, 8'h41, 8'h0D, 8'h0A}};
      logic [7:0] b;
      bit         ok, seen;
      int         t0, t_first, t_last, t_done;
      sel = 1;
      do_reset();
      for (int v = 0; v < 3; v++) begin
         pulse_req(din[v]);
         for (int k = 0; k < 4; k++) begin
            rx_char(CPB, b, ok, t0);
            if (k == 0) t_first = t0;
            t_last = t0;
            n_checks++;
            if (!ok || b !== exp[v][k])
               $display("FAIL hex_%h_char%0d: got %h ok=%0d want %h", din[v], k, b, ok, exp[v][k]);
            else n_pass++;
         end
         n_checks++;
         if ((t_last - t_first) !== 30 * CPB)
            $display("FAIL hex_%h_gapless: got %0d want %0d", din[v], t_last - t_first, 30 * CPB);
         else n_pass++;
         wait_done(2 * CPB, t_done, seen);
         n_checks++;
         if (!seen || (t_done - t_first) !== 40 * CPB)
            $display("FAIL hex_%h_done: got seen=%0d len=%0d want len %0d", din[v], seen, t_done - t_first, 40 * CPB);
         else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_hold_req();
      logic [7:0] exp1 [4] = '{8'h35, 8'h45, 8'h0D, 8'h0A};
      logic [7:0] exp2 [4] = '{8'h37, 8'h43, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit         ok, seen;
      int         t0, t_done;
      sel = 1;
      do_reset();
      send_data = 8'h5E;
      send_req  = 1'b1;
      @(negedge clk);
      send_data = 8'h12;
      for (int k = 0; k < 4; k++) begin
         rx_char(CPB, b, ok, t0);
         if (k == 0) send_data = 8'hE1;
         n_checks++;
         if (!ok || b !== exp1[k]) $display("FAIL hold_char%0d: got %h ok=%0d want %h", k, b, ok, exp1[k]);
         else n_pass++;
      end
      send_data = 8'h7C;
      wait_done(2 * CPB, t_done, seen);
      n_checks++;
      if (!seen || w_busy[1] !== 1'b0) $display("FAIL hold_done: got seen=%0d busy=%b want 1/0", seen, w_busy[1]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (w_busy[1] !== 1'b1 || w_txd[1] !== 1'b0)
         $display("FAIL hold_restart: got busy=%b txd=%b want 1/0", w_busy[1], w_txd[1]);
      else n_pass++;
      send_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rx_char(CPB, b, ok, t0);
         n_checks++;
         if (!ok || b !== exp2[k]) $display("FAIL hold2_char%0d: got %h ok=%0d want %h", k, b, ok, exp2[k]);
         else n_pass++;
      end
      wait_done(2 * CPB, t_done, seen);
      n_checks++;
      if (!seen) $display("FAIL hold2_done: got 0 want 1");
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp [4] = '{8'h43, 8'h37, 8'h0D, 8'h0A};
      logic [7:0] b;
      bit         ok, seen;
      int         t0, t_done;
      sel = 1;
      do_reset();
      pulse_req(8'hB4);
      // Centre of char idx1 data bit 3 ('4' = 0x34, bit 3 = 0).
      repeat (14 * CPB + CPB / 2) @(negedge clk);
      n_checks++;
      if (w_busy[1] !== 1'b1 || w_txd[1] !== 1'b0)
         $display("FAIL mid_before_rst: got busy=%b txd=%b want 1/0", w_busy[1], w_txd[1]);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if (w_txd[1] !== 1'b1 || w_busy[1] !== 1'b0 || w_done[1] !== 1'b0)
         $display("FAIL mid_async_rst: got txd=%b busy=%b done=%b want 1/0/0", w_txd[1], w_busy[1], w_done[1]);
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      pulse_req(8'hC7);
      for (int k = 0; k < 4; k++) begin
         rx_char(CPB, b, ok, t0);
         n_checks++;
         if (!ok || b !== exp[k]) $display("FAIL mid_resend_char%0d: got %h ok=%0d want %h", k, b, ok, exp[k]);
         else n_pass++;
      end
      wait_done(2 * CPB, t_done, seen);
      n_checks++;
      if (!seen) $display("FAIL mid_resend_done: got 0 want 1");
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_no_crlf();
      logic [7:0] exp [2] = '{8'h33, 8'h43};
      logic [7:0] b;
      bit         ok, seen, bad;
      int         t0, t_first, t_done;
      sel = 2;
      do_reset();
      pulse_req(8'h3C);
      for (int k = 0; k < 2; k++) begin
         rx_char(CPB, b, ok, t0);
         if (k == 0) t_first = t0;
         n_checks++;
         if (!ok || b !== exp[k]) $display("FAIL nocrlf_char%0d: got %h ok=%0d want %h", k, b, ok, exp[k]);
         else n_pass++;
      end
      wait_done(2 * CPB, t_done, seen);
      n_checks++;
      if (!seen || (t_done - t_first) !== 20 * CPB)
         $display("FAIL nocrlf_len: got seen=%0d len=%0d want %0d", seen, t_done - t_first, 20 * CPB);
      else n_pass++;
      bad = 1'b0;
      repeat (3 * CPB) begin
         @(negedge clk);
         if (w_txd[2] !== 1'b1 || w_busy[2] !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) $display("FAIL nocrlf_idle_after: got activity want idle line");
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_frame_default();
      test_hex_chars();
      test_hold_req();
      test_reset_mid();
      test_no_crlf();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
